// File: rtl/cache_refill_arbiter_pkg.sv
// Shared pipeline types: line bus type and the refill FSM state encoding.
package pipeline_types;

  typedef logic [255:0] bus256_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } refill_state_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/cache_refill_arbiter_rr.sv
// Combinational round-robin picker: search starts just after last_grant and wraps.
module rr_arbiter
  import pipeline_types::*;
#(
  parameter int N = 2,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int   cand;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_grant) + i) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Multi-client cache line refill: RR grant, one burst read per line, beat assembly, line return.
module cache_refill_arbiter
  import pipeline_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORTS-1:0]            rd_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]            rd_ack,
  output logic [NUM_PORTS-1:0]            ret_valid,
  output logic [LINE_WIDTH-1:0]           ret_data,
  output logic                            mem_ar_valid,
  input  logic                            mem_ar_ready,
  output logic [ADDR_WIDTH-1:0]           mem_ar_addr,
  output logic [7:0]                      mem_ar_len,
  input  logic                            mem_r_valid,
  output logic                            mem_r_ready,
  input  logic [BEAT_WIDTH-1:0]           mem_r_data,
  input  logic                            mem_r_last,
  output logic                            busy,
  output logic                            proto_err,
  output refill_state_t                   dbg_state
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CW    = clog2_min1(BEATS);
  localparam int IW    = clog2_min1(NUM_PORTS);
  localparam int OFFS  = $clog2(LINE_WIDTH / 8);
  localparam logic [CW-1:0]         LAST_BEAT  = CW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFS;

  // Handshakes: a transfer happens in a cycle where valid and ready are both high;
  // valid never depends on ready, and mem_ar_addr is stable while mem_ar_valid is high.

  refill_state_t          state_q, state_d;
  logic [IW-1:0]          rr_q, rr_d, idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;
  logic [CW-1:0]          beat_q, beat_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d;
  logic                   proto_err_q, proto_err_d;
  logic                   drain_q, drain_d;
  logic [NUM_PORTS-1:0]   grant;
  logic [IW-1:0]          grant_idx;
  logic                   beat_fire;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .req        (rd_req),
    .last_grant (rr_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign beat_fire = mem_r_valid && mem_r_ready;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    line_d      = line_q;
    beat_d      = beat_q;
    ack_d       = '0;
    proto_err_d = proto_err_q;
    drain_d     = drain_q;
    // Leftover beats of an overlong burst are swallowed until its r_last.
    if (drain_q && beat_fire && mem_r_last) drain_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|rd_req) begin
          idx_d   = grant_idx;
          rr_d    = grant_idx;
          addr_d  = rd_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          ack_d   = grant;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (mem_ar_ready) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat_fire && !drain_q) begin
          line_d[int'(beat_q)*BEAT_WIDTH +: BEAT_WIDTH] = mem_r_data;
          beat_d = beat_q + CW'(1);
          if (mem_r_last || (beat_q == LAST_BEAT)) begin
            state_d = RESP;
            if (mem_r_last != (beat_q == LAST_BEAT)) proto_err_d = 1'b1;
            if (!mem_r_last) drain_d = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      rr_q        <= IW'(NUM_PORTS - 1);
      idx_q       <= '0;
      addr_q      <= '0;
      line_q      <= '0;
      beat_q      <= '0;
      ack_q       <= '0;
      proto_err_q <= 1'b0;
      drain_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      line_q      <= line_d;
      beat_q      <= beat_d;
      ack_q       <= ack_d;
      proto_err_q <= proto_err_d;
      drain_q     <= drain_d;
    end
  end

  assign rd_ack       = ack_q;
  assign ret_valid    = (state_q == RESP) ? (NUM_PORTS'(1) << idx_q) : '0;
  assign ret_data     = line_q;
  assign mem_ar_valid = (state_q == ADDR);
  assign mem_ar_addr  = addr_q & ALIGN_MASK;
  assign mem_ar_len   = 8'(BEATS - 1);
  assign mem_r_ready  = (state_q == DATA) || drain_q;
  assign busy         = (state_q != IDLE);
  assign proto_err    = proto_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter with default parameters (2 ports, 8 x 32-bit beats).
module tb_cache_refill_arbiter;
  import pipeline_types::*;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [1:0]    rd_req;
  logic [63:0]   rd_addr;
  logic [1:0]    rd_ack;
  logic [1:0]    ret_valid;
  logic [255:0]  ret_data;
  logic          mem_ar_valid;
  logic          mem_ar_ready;
  logic [31:0]   mem_ar_addr;
  logic [7:0]    mem_ar_len;
  logic          mem_r_valid;
  logic          mem_r_ready;
  logic [31:0]   mem_r_data;
  logic          mem_r_last;
  logic          busy;
  logic          proto_err;
  refill_state_t dbg_state;

  int            total = 0;
  int            bad   = 0;
  logic [255:0]  exp_line;
  int            lat;

  cache_refill_arbiter dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .ret_valid    (ret_valid),
    .ret_data     (ret_data),
    .mem_ar_valid (mem_ar_valid),
    .mem_ar_ready (mem_ar_ready),
    .mem_ar_addr  (mem_ar_addr),
    .mem_ar_len   (mem_ar_len),
    .mem_r_valid  (mem_r_valid),
    .mem_r_ready  (mem_r_ready),
    .mem_r_data   (mem_r_data),
    .mem_r_last   (mem_r_last),
    .busy         (busy),
    .proto_err    (proto_err),
    .dbg_state    (dbg_state)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_ack"}, rd_ack, 2'b00);
    chk({tag, "_ret_valid"}, ret_valid, 2'b00);
    chk({tag, "_ar_valid"}, mem_ar_valid, 1'b0);
    chk({tag, "_r_ready"}, mem_r_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_proto_err"}, proto_err, 1'b0);
    chk({tag, "_ret_data"}, ret_data, 256'h0);
    chk({tag, "_ar_addr"}, mem_ar_addr, 32'h0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  // Bounded wait for a grant, then check port, address and burst length.
  task automatic wait_ack(input int port, input logic [31:0] exp_addr, output int cycles);
    logic [1:0] oh;
    bit got;
    oh = 2'b01 << port;
    got = 1'b0;
    cycles = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      cycles++;
      if (rd_ack != 2'b00) got = 1'b1;
    end
    chk("rd_ack", rd_ack, oh);
    chk("ar_valid_at_ack", mem_ar_valid, 1'b1);
    chk("ar_addr", mem_ar_addr, exp_addr);
    chk("ar_len", mem_ar_len, 8'd7);
  endtask

  task automatic send_beats(input int n, input int last_at, input logic [31:0] base, input bit gap);
    for (int k = 0; k < n; k++) begin
      if (gap) begin
        mem_r_valid = 1'b0;
        tick();
      end
      chk("r_ready", mem_r_ready, 1'b1);
      mem_r_valid = 1'b1;
      mem_r_data  = base + 32'(k);
      mem_r_last  = (k == last_at);
      exp_line[k*32 +: 32] = base + 32'(k);
      tick();
    end
    mem_r_valid = 1'b0;
    mem_r_last  = 1'b0;
  endtask

  task automatic finish_resp(input int port);
    logic [1:0] oh;
    oh = 2'b01 << port;
    chk("ret_valid", ret_valid, oh);
    chk("ret_data", ret_data, exp_line);
    tick();
    chk("ret_valid_pulse", ret_valid, 2'b00);
    chk("idle_after_resp", dbg_state, IDLE);
  endtask

  initial begin
    aresetn      = 1'b0;
    rd_req       = '0;
    rd_addr      = '0;
    mem_ar_ready = 1'b1;
    mem_r_valid  = 1'b0;
    mem_r_data   = '0;
    mem_r_last   = 1'b0;
    exp_line     = '0;
    tick();
    tick();
    chk_reset_outputs("rst");
    aresetn = 1'b1;
    tick();
    chk_reset_outputs("post_rst");

    // Single request, port 0, best-case timing.
    rd_addr[31:0] = 32'h1C00_0034;
    rd_req        = 2'b01;
    wait_ack(0, 32'h1C00_0020, lat);
    chk("ack_latency", 32'(lat), 32'd1);
    rd_req = 2'b00;
    tick();
    chk("single_state_data", dbg_state, DATA);
    chk("single_ar_drop", mem_ar_valid, 1'b0);
    send_beats(8, 7, 32'h0, 1'b0);
    chk("single_beat0", ret_data[31:0], 32'd0);
    chk("single_beat7", ret_data[255:224], 32'd7);
    chk("single_proto", proto_err, 1'b0);
    finish_resp(0);

    // Backpressure: ar_ready low 3 cycles, then r_valid every other cycle, port 1.
    mem_ar_ready   = 1'b0;
    rd_addr[63:32] = 32'h3000_00FF;
    rd_req         = 2'b10;
    wait_ack(1, 32'h3000_00E0, lat);
    rd_req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ar_valid_held", mem_ar_valid, 1'b1);
      chk("bp_ar_addr_stable", mem_ar_addr, 32'h3000_00E0);
      tick();
    end
    mem_ar_ready = 1'b1;
    chk("bp_ar_valid_final", mem_ar_valid, 1'b1);
    tick();
    chk("bp_state_data", dbg_state, DATA);
    send_beats(8, 7, 32'hB0, 1'b1);
    chk("bp_proto", proto_err, 1'b0);
    finish_resp(1);
    tick();
    chk("bp_no_second_pulse", ret_valid, 2'b00);

    // Early r_last on beat 5: beats 6..7 keep the previous line's values.
    rd_addr[31:0] = 32'h4000_0010;
    rd_req        = 2'b01;
    wait_ack(0, 32'h4000_0000, lat);
    rd_req = 2'b00;
    tick();
    chk("early_proto_before", proto_err, 1'b0);
    send_beats(6, 5, 32'hA0, 1'b0);
    chk("early_state_resp", dbg_state, RESP);
    chk("early_proto_after", proto_err, 1'b1);
    chk("early_stale_beats", ret_data[255:192], {32'hB7, 32'hB6});
    finish_resp(0);

    // Reset asserted while beat 3 is on the bus.
    rd_addr[63:32] = 32'h5000_0040;
    rd_req         = 2'b10;
    wait_ack(1, 32'h5000_0040, lat);
    rd_req = 2'b00;
    tick();
    send_beats(3, 99, 32'hC0, 1'b0);
    mem_r_valid = 1'b1;
    mem_r_data  = 32'hC3;
    #2;
    aresetn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    mem_r_valid = 1'b0;
    tick();
    chk_reset_outputs("midrst_hold");
    aresetn  = 1'b1;
    exp_line = '0;

    // Contention: both ports request continuously, grants alternate from port 0.
    rd_addr = {32'h2000_0085, 32'h1000_0040};
    rd_req  = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_ack(t % 2, (t % 2 == 1) ? 32'h2000_0080 : 32'h1000_0040, lat);
      tick();
      send_beats(8, 7, 32'h100 * 32'(t + 1), 1'b0);
      finish_resp(t % 2);
    end
    rd_req = 2'b00;

    // Request dropped right after its ack still completes.
    rd_addr[63:32] = 32'h6000_0123;
    rd_req         = 2'b10;
    wait_ack(1, 32'h6000_0120, lat);
    rd_req = 2'b00;
    tick();
    chk("drop_busy", busy, 1'b1);
    send_beats(8, 7, 32'hD0, 1'b0);
    finish_resp(1);
    chk("drop_final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
